// File: rtl/vote_window_ctrl.sv
// Collection-window controller for the root voter.
// Accepts one signature per active core, opens a timeout window on the first
// arrival via an external countdown counter, then votes once all active cores
// have reported or the window has expired, and holds the result until acked.
module vote_window_ctrl #(
  parameter int NCORES   = 4,
  parameter int SIGWIDTH = 32,
  parameter int DWIDTH   = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NCORES-1:0]            active_mask,
  input  logic [DWIDTH-1:0]            timeout_val,
  input  logic [NCORES-1:0]            sig_valid,
  input  logic [NCORES*SIGWIDTH-1:0]   sig_data,
  output logic [NCORES-1:0]            sig_ready,
  output logic [DWIDTH-1:0]            cnt_d,
  output logic                         cnt_load,
  output logic                         cnt_en,
  input  logic                         cnt_expired,
  output logic                         result_valid,
  input  logic                         result_ack,
  output logic                         vote_ok,
  output logic                         timed_out,
  output logic [SIGWIDTH-1:0]          voted_sig,
  output logic [NCORES-1:0]            match_mask,
  output logic [NCORES-1:0]            fault_mask,
  output logic                         busy
);

  // One spare bit so that 2*count never overflows the comparison width.
  localparam int CW = $clog2(NCORES + 1) + 1;

  typedef enum logic [1:0] {IDLE, COLLECT, VOTE, REPORT} state_t;

  state_t                state;
  logic [NCORES-1:0]     act_lat;
  logic [NCORES-1:0]     captured;
  logic [NCORES-1:0]     act;
  logic [NCORES-1:0]     ready;
  logic [NCORES-1:0]     xfer;
  logic [NCORES-1:0]     cap_next;
  logic                  to_pend;
  logic [SIGWIDTH-1:0]   sig_q [NCORES];
  logic [CW-1:0]         n_act;
  logic [NCORES-1:0]     maj_mask;
  logic [SIGWIDTH-1:0]   maj_sig;

  function automatic logic [CW-1:0] popcount(input logic [NCORES-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < NCORES; i++) c = c + CW'(v[i]);
    return c;
  endfunction

  // Accept window: live mask while idle, latched mask once the window is open.
  always_comb begin
    act   = (state == IDLE) ? active_mask : act_lat;
    ready = '0;
    if (!reset && (state == IDLE || state == COLLECT))
      ready = act & ~captured;
  end

  assign xfer      = ready & sig_valid;
  assign cap_next  = captured | xfer;
  assign sig_ready = ready;
  // Load is issued in the opening cycle so the first COLLECT cycle already
  // sees the preloaded value (a preload of 0 expires immediately).
  assign cnt_load  = (state == IDLE) && (xfer != '0);
  assign cnt_d     = cnt_load ? timeout_val : '0;
  assign cnt_en    = !reset && (state == COLLECT);
  assign busy      = (state != IDLE);

  // Majority vote over captured signatures, judged against the latched core count.
  always_comb begin
    logic [CW-1:0] eq;
    n_act    = popcount(act_lat);
    maj_mask = '0;
    maj_sig  = '0;
    for (int i = 0; i < NCORES; i++) begin
      eq = '0;
      for (int j = 0; j < NCORES; j++)
        if (captured[j] && sig_q[j] == sig_q[i]) eq = eq + 1'b1;
      if (captured[i] && ((eq << 1) > n_act)) begin
        maj_mask[i] = 1'b1;
        maj_sig     = sig_q[i];
      end
    end
  end

  // Signature capture on each accepted transfer; datapath storage, no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NCORES; i++)
      if (xfer[i]) sig_q[i] <= sig_data[i*SIGWIDTH +: SIGWIDTH];
  end

  // Window state machine with registered result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      act_lat      <= '0;
      captured     <= '0;
      to_pend      <= 1'b0;
      result_valid <= 1'b0;
      vote_ok      <= 1'b0;
      timed_out    <= 1'b0;
      voted_sig    <= '0;
      match_mask   <= '0;
      fault_mask   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (xfer != '0) begin
            act_lat  <= active_mask;
            captured <= xfer;
            to_pend  <= 1'b0;
            state    <= (xfer == active_mask) ? VOTE : COLLECT;
          end
        end
        COLLECT: begin
          captured <= cap_next;
          // A completing arrival takes precedence over a simultaneous expiry.
          if ((cap_next & act_lat) == act_lat) begin
            to_pend <= 1'b0;
            state   <= VOTE;
          end else if (cnt_expired) begin
            to_pend <= 1'b1;
            state   <= VOTE;
          end
        end
        VOTE: begin
          result_valid <= 1'b1;
          vote_ok      <= (maj_mask != '0);
          timed_out    <= to_pend;
          voted_sig    <= maj_sig;
          match_mask   <= maj_mask;
          fault_mask   <= act_lat & ~maj_mask;
          state        <= REPORT;
        end
        REPORT: begin
          if (result_ack) begin
            result_valid <= 1'b0;
            captured     <= '0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vote_window_ctrl.sv
// Directed bench for vote_window_ctrl with a behavioural countdown counter.
module tb_vote_window_ctrl;

  localparam int NC = 4;
  localparam int SW = 32;
  localparam int DW = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [NC-1:0]     active_mask;
  logic [DW-1:0]     timeout_val;
  logic [NC-1:0]     sig_valid;
  logic [NC*SW-1:0]  sig_data;
  logic [NC-1:0]     sig_ready;
  logic [DW-1:0]     cnt_d;
  logic              cnt_load;
  logic              cnt_en;
  logic              cnt_expired;
  logic              result_valid;
  logic              result_ack;
  logic              vote_ok;
  logic              timed_out;
  logic [SW-1:0]     voted_sig;
  logic [NC-1:0]     match_mask;
  logic [NC-1:0]     fault_mask;
  logic              busy;

  logic [SW-1:0]     tsig [NC];
  logic [DW-1:0]     cnt;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  assign sig_data = {tsig[3], tsig[2], tsig[1], tsig[0]};

  // Downstream countdown counter model.
  always_ff @(posedge clk) begin
    if (reset) cnt <= '0;
    else if (cnt_load) cnt <= cnt_d;
    else if (cnt_en && cnt != '0) cnt <= cnt - 1'b1;
  end
  assign cnt_expired = (cnt == '0);

  vote_window_ctrl #(.NCORES(NC), .SIGWIDTH(SW), .DWIDTH(DW)) dut (
    .clk(clk), .reset(reset), .active_mask(active_mask), .timeout_val(timeout_val),
    .sig_valid(sig_valid), .sig_data(sig_data), .sig_ready(sig_ready),
    .cnt_d(cnt_d), .cnt_load(cnt_load), .cnt_en(cnt_en), .cnt_expired(cnt_expired),
    .result_valid(result_valid), .result_ack(result_ack), .vote_ok(vote_ok),
    .timed_out(timed_out), .voted_sig(voted_sig), .match_mask(match_mask),
    .fault_mask(fault_mask), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic wait_rv(input int lim, output int n);
    n = 0;
    while (result_valid !== 1'b1 && n < lim) begin
      tick();
      n++;
    end
  endtask

  task automatic ack_result();
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
    settle();
    vecs++;
    if (result_valid !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL ack_release: rv=%b busy=%b want rv=0 busy=0", result_valid, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; active_mask = 4'hF; timeout_val = 16'd3; sig_valid = 4'hF; result_ack = 1'b0;
    for (int i = 0; i < NC; i++) tsig[i] = 32'h0;
    tick(); tick();
    settle();
    vecs++;
    if ({sig_ready, cnt_load, cnt_en, cnt_d, result_valid, busy, vote_ok, timed_out,
         voted_sig, match_mask, fault_mask} !== '0) begin
      errs++;
      $display("FAIL reset_outputs: rdy=%h load=%b en=%b d=%h rv=%b busy=%b ok=%b to=%b sig=%h mm=%h fm=%h want all 0",
               sig_ready, cnt_load, cnt_en, cnt_d, result_valid, busy, vote_ok, timed_out,
               voted_sig, match_mask, fault_mask);
    end
    sig_valid = 4'h0;
    tick();
    reset = 1'b0;
    settle();
    vecs++;
    if (sig_ready !== 4'hF || busy !== 1'b0) begin
      errs++;
      $display("FAIL reset_release: rdy=%h busy=%b want rdy=f busy=0", sig_ready, busy);
    end
  endtask

  task automatic test_all_same();
    tick();
    active_mask = 4'hF; timeout_val = 16'd10;
    for (int i = 0; i < NC; i++) tsig[i] = 32'hCAFE0001;
    sig_valid = 4'hF;
    settle();
    vecs++;
    if (cnt_load !== 1'b1 || cnt_d !== 16'd10) begin
      errs++;
      $display("FAIL same_load: load=%b d=%0d want load=1 d=10", cnt_load, cnt_d);
    end
    tick();
    sig_valid = 4'h0;
    settle();
    vecs++;
    if (result_valid !== 1'b0 || busy !== 1'b1 || cnt_load !== 1'b0) begin
      errs++;
      $display("FAIL same_vote_cycle: rv=%b busy=%b load=%b want 0 1 0", result_valid, busy, cnt_load);
    end
    tick();
    vecs++;
    if (result_valid !== 1'b1 || vote_ok !== 1'b1 || timed_out !== 1'b0 ||
        voted_sig !== 32'hCAFE0001 || match_mask !== 4'hF || fault_mask !== 4'h0) begin
      errs++;
      $display("FAIL same_result: rv=%b ok=%b to=%b sig=%h mm=%h fm=%h want 1 1 0 cafe0001 f 0",
               result_valid, vote_ok, timed_out, voted_sig, match_mask, fault_mask);
    end
    ack_result();
  endtask

  task automatic test_staggered();
    int n;
    active_mask = 4'hF; timeout_val = 16'd10;
    tsig[0] = 32'hA; tsig[1] = 32'hA; tsig[2] = 32'hB; tsig[3] = 32'hA;
    sig_valid = 4'b0001;
    settle();
    vecs++;
    if (cnt_load !== 1'b1) begin
      errs++;
      $display("FAIL stag_load: load=%b want 1", cnt_load);
    end
    tick();
    sig_valid = 4'b0011;
    settle();
    vecs++;
    if (sig_ready !== 4'b1110 || cnt_en !== 1'b1) begin
      errs++;
      $display("FAIL stag_ready: rdy=%b en=%b want 1110 1", sig_ready, cnt_en);
    end
    tick();
    sig_valid = 4'b0100;
    tick();
    sig_valid = 4'b1000;
    tick();
    sig_valid = 4'b0000;
    wait_rv(20, n);
    vecs++;
    if (n !== 1) begin
      errs++;
      $display("FAIL stag_latency: cycles=%0d want 1", n);
    end
    vecs++;
    if (voted_sig !== 32'hA || match_mask !== 4'b1011 || fault_mask !== 4'b0100 ||
        vote_ok !== 1'b1 || timed_out !== 1'b0) begin
      errs++;
      $display("FAIL stag_result: sig=%h mm=%b fm=%b ok=%b to=%b want a 1011 0100 1 0",
               voted_sig, match_mask, fault_mask, vote_ok, timed_out);
    end
    ack_result();
  endtask

  task automatic test_timeout();
    int n;
    tick();
    active_mask = 4'b0111; timeout_val = 16'd5;
    tsig[0] = 32'h55; tsig[1] = 32'h55; tsig[2] = 32'h0;
    sig_valid = 4'b0011;
    tick();
    sig_valid = 4'b0000;
    settle();
    vecs++;
    if (cnt_en !== 1'b1 || cnt_load !== 1'b0 || sig_ready !== 4'b0100) begin
      errs++;
      $display("FAIL tmo_collect: en=%b load=%b rdy=%b want 1 0 0100", cnt_en, cnt_load, sig_ready);
    end
    wait_rv(40, n);
    vecs++;
    if (n !== 7) begin
      errs++;
      $display("FAIL tmo_latency: cycles=%0d want 7", n);
    end
    vecs++;
    if (timed_out !== 1'b1 || vote_ok !== 1'b1 || voted_sig !== 32'h55 ||
        match_mask !== 4'b0011 || fault_mask !== 4'b0100) begin
      errs++;
      $display("FAIL tmo_result: to=%b ok=%b sig=%h mm=%b fm=%b want 1 1 55 0011 0100",
               timed_out, vote_ok, voted_sig, match_mask, fault_mask);
    end
    ack_result();
  endtask

  task automatic test_tie();
    tick();
    active_mask = 4'hF; timeout_val = 16'd10;
    tsig[0] = 32'h1; tsig[1] = 32'h1; tsig[2] = 32'h2; tsig[3] = 32'h2;
    sig_valid = 4'hF;
    tick();
    sig_valid = 4'h0;
    tick();
    vecs++;
    if (result_valid !== 1'b1 || vote_ok !== 1'b0 || voted_sig !== 32'h0 ||
        match_mask !== 4'h0 || fault_mask !== 4'hF || timed_out !== 1'b0) begin
      errs++;
      $display("FAIL tie_result: rv=%b ok=%b sig=%h mm=%h fm=%h to=%b want 1 0 0 0 f 0",
               result_valid, vote_ok, voted_sig, match_mask, fault_mask, timed_out);
    end
    ack_result();
  endtask

  task automatic test_expiry_race();
    int n;
    // Last core lands in the very cycle the counter reaches zero.
    tick();
    active_mask = 4'b0011; timeout_val = 16'd2;
    tsig[0] = 32'h77; tsig[1] = 32'h77;
    sig_valid = 4'b0001;
    tick();
    sig_valid = 4'b0000;
    tick();
    tick();
    sig_valid = 4'b0010;
    tick();
    sig_valid = 4'b0000;
    wait_rv(20, n);
    vecs++;
    if (n !== 1) begin
      errs++;
      $display("FAIL race_latency: cycles=%0d want 1", n);
    end
    vecs++;
    if (timed_out !== 1'b0 || vote_ok !== 1'b1 || match_mask !== 4'b0011 ||
        fault_mask !== 4'b0000 || voted_sig !== 32'h77) begin
      errs++;
      $display("FAIL race_result: to=%b ok=%b mm=%b fm=%b sig=%h want 0 1 0011 0000 77",
               timed_out, vote_ok, match_mask, fault_mask, voted_sig);
    end
    ack_result();
    // Zero-length window: core 1 turns up only after expiry and is refused.
    tick();
    timeout_val = 16'd0;
    sig_valid = 4'b0001;
    tick();
    sig_valid = 4'b0000;
    tick();
    sig_valid = 4'b0010;
    settle();
    vecs++;
    if (sig_ready !== 4'b0000) begin
      errs++;
      $display("FAIL zero_late_ready: rdy=%b want 0000", sig_ready);
    end
    tick();
    sig_valid = 4'b0000;
    vecs++;
    if (result_valid !== 1'b1 || timed_out !== 1'b1 || vote_ok !== 1'b0 ||
        match_mask !== 4'b0000 || fault_mask !== 4'b0011 || voted_sig !== 32'h0) begin
      errs++;
      $display("FAIL zero_result: rv=%b to=%b ok=%b mm=%b fm=%b sig=%h want 1 1 0 0000 0011 0",
               result_valid, timed_out, vote_ok, match_mask, fault_mask, voted_sig);
    end
    ack_result();
  endtask

  task automatic test_reset_mid();
    tick();
    active_mask = 4'hF; timeout_val = 16'd10;
    tsig[0] = 32'h9;
    sig_valid = 4'b0001;
    tick();
    sig_valid = 4'b0000;
    settle();
    vecs++;
    if (busy !== 1'b1) begin
      errs++;
      $display("FAIL mid_busy: busy=%b want 1", busy);
    end
    tick();
    reset = 1'b1;
    settle();
    vecs++;
    if (cnt_en !== 1'b0 || cnt_load !== 1'b0 || sig_ready !== 4'h0) begin
      errs++;
      $display("FAIL mid_reset_ctrl: en=%b load=%b rdy=%h want 0 0 0", cnt_en, cnt_load, sig_ready);
    end
    tick();
    reset = 1'b0;
    settle();
    vecs++;
    if (busy !== 1'b0 || sig_ready !== 4'hF || result_valid !== 1'b0) begin
      errs++;
      $display("FAIL mid_after: busy=%b rdy=%h rv=%b want 0 f 0", busy, sig_ready, result_valid);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      vecs++;
      if (result_valid !== 1'b0 || busy !== 1'b0) begin
        errs++;
        $display("FAIL mid_quiet[%0d]: rv=%b busy=%b want 0 0", k, result_valid, busy);
      end
    end
  endtask

  task automatic test_hold();
    active_mask = 4'hF; timeout_val = 16'd10;
    tsig[0] = 32'h7; tsig[1] = 32'h7; tsig[2] = 32'h7; tsig[3] = 32'h9;
    sig_valid = 4'hF;
    tick();
    sig_valid = 4'h0;
    tick();
    // Fresh valids and new data while reporting must not disturb the result.
    tsig[0] = 32'h3; tsig[1] = 32'h3; tsig[2] = 32'h3; tsig[3] = 32'h3;
    sig_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      settle();
      vecs++;
      if (result_valid !== 1'b1 || vote_ok !== 1'b1 || timed_out !== 1'b0 ||
          voted_sig !== 32'h7 || match_mask !== 4'b0111 || fault_mask !== 4'b1000 ||
          sig_ready !== 4'h0 || busy !== 1'b1) begin
        errs++;
        $display("FAIL hold[%0d]: rv=%b ok=%b to=%b sig=%h mm=%b fm=%b rdy=%h busy=%b want 1 1 0 7 0111 1000 0 1",
                 k, result_valid, vote_ok, timed_out, voted_sig, match_mask, fault_mask, sig_ready, busy);
      end
      tick();
    end
    sig_valid = 4'h0;
    ack_result();
    // Ack while idle has no effect.
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
    settle();
    vecs++;
    if (busy !== 1'b0 || result_valid !== 1'b0 || sig_ready !== 4'hF) begin
      errs++;
      $display("FAIL idle_ack: busy=%b rv=%b rdy=%h want 0 0 f", busy, result_valid, sig_ready);
    end
  endtask

  initial begin
    test_reset();
    test_all_same();
    test_staggered();
    test_timeout();
    test_tie();
    test_expiry_race();
    test_reset_mid();
    test_hold();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/vote_window_ctrl.md
Name: vote_window_ctrl

Overview:
- Collection-window controller for the root voter. It accepts one result signature per redundant core and opens a timeout window on the first arrival.
- It drives the load/enable of the downstream countdown timeout counter and consumes that counter's expired flag.
- When all active cores have reported, or the window expires, it performs a majority vote and reports the voted signature, a match mask and a fault mask to the safety manager.

Parameters:
- NCORES, 4, number of redundant cores voted.
- SIGWIDTH, 32, width of one result signature.
- DWIDTH, 16, width of the timeout counter preload value.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- active_mask  input  NCORES  cores taking part in the vote; sampled when the window opens.
- timeout_val  input  DWIDTH  window length in cycles; sampled when the window opens.
- sig_valid  input  NCORES  per-core signature valid.
- sig_data  input  NCORES*SIGWIDTH  per-core signatures; core i occupies bits [i*SIGWIDTH +: SIGWIDTH].
- sig_ready  output  NCORES  per-core accept.
- cnt_d  output  DWIDTH  counter preload value.
- cnt_load  output  1  counter load strobe.
- cnt_en  output  1  counter decrement enable.
- cnt_expired  input  1  counter value equals zero.
- result_valid  output  1  vote result available.
- result_ack  input  1  consumer accepts the result.
- vote_ok  output  1  a strict majority exists.
- timed_out  output  1  window ended by expiry.
- voted_sig  output  SIGWIDTH  majority signature; 0 if there is no majority.
- match_mask  output  NCORES  cores in the majority group.
- fault_mask  output  NCORES  active cores not in the majority group, including cores that never arrived.
- busy  output  1  state is not IDLE.

Behaviour:
- Reset values: all outputs 0, state IDLE, captured mask 0, latched active mask 0.
- Reset has priority in every state; mid-window it aborts the window with no result and drives cnt_load=0 and cnt_en=0.

Handshake:
- sig_ready[i] = (IDLE or COLLECT) & act[i] & ~captured[i].
- In IDLE, act is the live active_mask; from the window opening onwards it is the latched mask.
- A transfer occurs when sig_valid[i] and sig_ready[i] are both high. The signature is registered and captured[i] is set.
- Each core is accepted at most once per window. Valid from inactive or already-captured cores is ignored.

State machine: IDLE, COLLECT, VOTE, REPORT.
- IDLE:
  - cnt_en=0 and cnt_expired is ignored; the counter idles at 0 after reset, so expired=1 here.
  - On the first cycle with any transfer: latch active_mask, pulse cnt_load=1 with cnt_d=timeout_val.
  - If every active core transferred that cycle, go to VOTE; otherwise go to COLLECT.
  - If active_mask is 0, nothing is accepted and the state stays IDLE.
- COLLECT:
  - cnt_en=1 every cycle and transfers continue.
  - If captured | current transfers covers the latched mask, go to VOTE with timed_out=0.
  - Else if cnt_expired, go to VOTE with timed_out=1.
  - An arrival that completes the set in the same cycle as expiry wins: timed_out=0.
  - timeout_val=0 expires on the first COLLECT cycle.
- VOTE (one cycle), with N = popcount(latched mask):
  - For each captured core i, eq_i = number of captured cores whose signature equals sig_i.
  - Majority holds when 2*eq_i > N.
  - match_mask = captured cores in the majority group; voted_sig = their signature.
  - vote_ok=1 if match_mask is non-zero; fault_mask = latched mask & ~match_mask.
  - Result registers are written at the end of this cycle; cnt_en=0.
- REPORT:
  - result_valid=1; all result outputs are held stable until result_ack.
  - On result_valid & result_ack: result_valid drops next cycle, the captured mask clears, state returns to IDLE.
  - result_ack outside REPORT is ignored.

Latency and boundaries:
- Completing arrival in cycle t gives VOTE at t+1 and result_valid at t+2.
- Expiry observed at t gives result_valid at t+2.
- Ties (e.g. 2-2 with N=4) give vote_ok=0, match_mask=0, voted_sig=0, fault_mask=latched mask.
- Majority is judged against N, not the captured count, so missing cores count against it.

Test Plan:
- NCORES=4, mask=4'hF, timeout_val=10, all four send 0xCAFE0001 in the same cycle → cnt_load pulse, result_valid 2 cycles later, vote_ok=1, match_mask=4'hF, fault_mask=0, timed_out=0.
- Cores 0, 1, 3 send 0xA, core 2 sends 0xB on staggered cycles within the window → voted_sig=0xA, match_mask=4'b1011, fault_mask=4'b0100.
- mask=4'b0111, timeout_val=5, cores 0 and 1 send 0x55, core 2 is silent → expiry ends the window, timed_out=1, vote_ok=1 (2*2>3), fault_mask=4'b0100.
- mask=4'hF, 0x1,0x1,0x2,0x2 → tie: vote_ok=0, voted_sig=0, fault_mask=4'hF.
- Last core arrives in the same cycle cnt_expired rises → timed_out=0, full match. Repeat with timeout_val=0 and one late core → timed_out=1.
- Assert reset during COLLECT → next cycle busy=0 and sig_ready equals active_mask, with no result_valid. A result_valid held 5 cycles without ack keeps all outputs stable.
